booth_radix4_multiplier: RTL and testbench
==========================================

BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (even, >= 4).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, request to begin a multiply.
REQ-005 SHALL have port op1, input, WIDTH bits, signed multiplicand (two's complement).
REQ-006 SHALL have port op2, input, WIDTH bits, signed multiplier (two's complement).
REQ-007 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, 2*WIDTH bits, signed product.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 SHALL accept start only in IDLE or DONE, latching op1 and op2 on that edge.
REQ-012 SHALL ignore start while in RUN; the running operation continues with its latched operands.
REQ-013 SHALL, on accept, go to RUN with P=0, multiplicand register MC = sign-extend(op1) to 2*WIDTH, multiplier register M = {op2, 1'b0} (WIDTH+1 bits), and step counter = 0.
REQ-014 SHALL, each RUN cycle, recode M[2:0] as Booth digit in {-2,-1,0,+1,+2}, add digit*MC to P modulo 2^(2*WIDTH), shift MC left by 2, and arithmetic-shift M right by 2.
REQ-015 SHALL, after WIDTH/2 RUN steps, go to DONE (8 steps for WIDTH=16).
REQ-016 SHALL give fixed latency when the early-termination feature is absent: start accepted at edge k gives done=1 and a valid result after edge k+WIDTH/2.
REQ-017 SHALL assert busy exactly while the state is RUN.
REQ-018 SHALL assert done exactly while the state is DONE, for one cycle, then return to IDLE unless a new start is accepted on that edge.
REQ-019 SHALL update result only on entry to DONE, and hold it until the next DONE.
REQ-020 SHALL produce the exact signed product for all operands, including -2^(WIDTH-1) * -2^(WIDTH-1); no overflow is possible.

Reset
REQ-021 SHALL, when rst is high at a clock edge, force IDLE, busy=0, done=0, result=0, and clear P, MC, M and the counter.
REQ-022 SHALL give rst priority over start and abort any RUN in progress without asserting done.

Configuration
REQ-023 SHALL compile early termination in only when BOOTH_EARLY_TERM_EN is defined: after any RUN step, if all bits of the shifted M are equal, the FSM goes to DONE on that edge with result = P.
REQ-024 SHALL, without BOOTH_EARLY_TERM_EN, always run exactly WIDTH/2 steps; results SHALL be identical in both builds, with only latency differing.

Structure
REQ-025 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the Booth digit encoding constants in shared package alu_pkg.
REQ-026 SHALL implement the digit recoding in sub-module booth_recoder (M[2:0] in; neg, zero, two out); the adder and FSM stay in the top module.

Verification (WIDTH=16)
REQ-027 SHALL cover: op1=3, op2=4, start pulse -> done after 8 cycles, result=12, busy high for exactly 8 cycles.
REQ-028 SHALL cover: op1=-32768, op2=-32768 -> result=32'h40000000; op1=32767, op2=-32768 -> result=-1073709056.
REQ-029 SHALL cover: start re-asserted with op1=5, op2=5 at RUN step 3 of 7*9 -> ignored, result=63.
REQ-030 SHALL cover: rst high during RUN step 4 -> next cycle busy=0, done=0, result=0, and no done pulse follows.
REQ-031 SHALL cover: back-to-back start in DONE (2*3, then -7*6) -> results 6, then -42, with no idle cycle between operations.
REQ-032 SHALL cover: with BOOTH_EARLY_TERM_EN defined, op1=3, op2=5 -> done after 2 RUN cycles, result=15; op2=0 -> done after 1 RUN cycle, result=0.
REQ-033 SHALL cover random signed operands (>= 1000 pairs) against a behavioural product model in both builds.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and digit codes.
// A digit code is {neg, zero, two}; magnitude 1 when two is clear.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic two;
    } booth_dig_t;

    localparam booth_dig_t DIG_Z  = 3'b010;
    localparam booth_dig_t DIG_P1 = 3'b000;
    localparam booth_dig_t DIG_P2 = 3'b001;
    localparam booth_dig_t DIG_M1 = 3'b100;
    localparam booth_dig_t DIG_M2 = 3'b101;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a signed digit.
module booth_recoder
    import alu_pkg::*;
(
    input  logic [2:0] bits,
    output logic       neg,
    output logic       zero,
    output logic       two
);

    booth_dig_t d;

    always_comb begin
        d = DIG_Z;
        unique case (bits)
            3'b000, 3'b111: d = DIG_Z;
            3'b001, 3'b010: d = DIG_P1;
            3'b011:         d = DIG_P2;
            3'b100:         d = DIG_M2;
            3'b101, 3'b110: d = DIG_M1;
            default:        d = DIG_Z;
        endcase
    end

    assign {neg, zero, two} = d;

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth signed multiplier, one digit per clock.
// Define BOOTH_EARLY_TERM_EN to stop once the remaining multiplier is all sign bits.
module booth_radix4_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS);

    state_e        state;
    logic [PW-1:0] p;
    logic [PW-1:0] mc;
    logic [WIDTH:0] m;
    logic [CW-1:0] cnt;

    logic          neg;
    logic          zero;
    logic          two;
    logic [PW-1:0] sel;
    logic [PW-1:0] addend;
    logic [PW-1:0] p_nxt;
    logic [WIDTH:0] m_nxt;
    logic          last;

    booth_recoder u_rec (
        .bits (m[2:0]),
        .neg  (neg),
        .zero (zero),
        .two  (two)
    );

    always_comb begin
        sel    = two ? {mc[PW-2:0], 1'b0} : mc;
        addend = zero ? '0 : (neg ? -sel : sel);
        p_nxt  = p + addend;
        m_nxt  = {{2{m[WIDTH]}}, m[WIDTH:2]};
`ifdef BOOTH_EARLY_TERM_EN
        // All-equal remainder recodes to zero digits only.
        last = (cnt == CW'(STEPS - 1)) || (&m_nxt) || ~(|m_nxt);
`else
        last = (cnt == CW'(STEPS - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            p      <= '0;
            mc     <= '0;
            m      <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    p   <= p_nxt;
                    mc  <= {mc[PW-3:0], 2'b00};
                    m   <= m_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= p_nxt;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        p     <= '0;
                        mc    <= {{WIDTH{op1[WIDTH-1]}}, op1};
                        m     <= {op2, 1'b0};
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Scoreboard bench for booth_radix4_multiplier (WIDTH=16).
module tb_booth_radix4_multiplier;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] expq[$];

    always #5 clk = ~clk;

    booth_radix4_multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] prod(input logic signed [W-1:0] a,
                                            input logic signed [W-1:0] b);
        logic signed [2*W-1:0] r;
        r = a * b;
        return r;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
        logic [W:0] mm;
        mm = {b, 1'b0};
        for (int i = 1; i <= W / 2; i++) begin
            mm = {{2{mm[W]}}, mm[W:2]};
            if (mm == '0 || &mm) return i;
        end
        return W / 2;
`else
        return W / 2;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest expected product.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (expq.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result", result, expq.pop_front());
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] e, input bit push);
        @(negedge clk);
        op1   = a;
        op2   = b;
        start = 1'b1;
        if (push) expq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int want, input int n0);
        int n;
        int bc;
        n  = n0;
        bc = n0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk({tag, "_timeout"}, 1, 0);
        chk({tag, "_lat"}, n, want);
        chk({tag, "_busy_cycles"}, bc, want);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst   = 1'b1;
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);

        issue(16'd3, 16'd4, 32'd12, 1);
        wait_done("3x4", exp_lat(16'd4), 0);

        issue(16'h8000, 16'h8000, 32'h4000_0000, 1);
        wait_done("min_min", exp_lat(16'h8000), 0);

        issue(16'h7fff, 16'h8000, 32'hC000_8000, 1);
        wait_done("max_min", exp_lat(16'h8000), 0);

        // Start re-asserted mid-run must be ignored.
        issue(16'd7, 16'd9, 32'd63, 1);
        @(negedge clk);
        @(negedge clk);
        op1   = 16'd5;
        op2   = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", exp_lat(16'd9), 3);
        repeat (3) @(negedge clk);
        chk("ignore_start_idle", busy, 0);

        // Reset mid-run aborts with no done pulse afterwards.
        issue(16'd7, 16'h4321, 32'd0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        repeat (12) @(negedge clk);
        chk("abort_idle", busy, 0);

        // Back-to-back: new start accepted in the DONE cycle.
        issue(16'd2, 16'd3, 32'd6, 1);
        wait_done("b2b_first", exp_lat(16'd3), 0);
        op1   = 16'hfff9;
        op2   = 16'd6;
        start = 1'b1;
        expq.push_back(32'hFFFF_FFD6);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", busy, 1);
        wait_done("b2b_second", exp_lat(16'd6), 0);

        issue(16'd3, 16'd5, 32'd15, 1);
        wait_done("3x5", exp_lat(16'd5), 0);
        issue(16'd3, 16'd0, 32'd0, 1);
        wait_done("3x0", exp_lat(16'd0), 0);

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            issue(a, b, prod(a, b), 1);
            wait_done("rand", exp_lat(b), 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
